// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Byte-serial program loader for the instruction memory. Takes a
// length-prefixed byte stream over a valid/ready handshake:
//    LEN_HI, LEN_LO (N, big-endian word count), N x 4 data bytes MSB first,
//    [checksum byte when LOADER_CHECKSUM_EN is defined]
// It assembles big-endian 32-bit words and writes each one to consecutive
// word addresses starting at BASE_ADDR. The CPU is held for the whole load.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//    defined   - a trailing XOR checksum byte (XOR of every byte since start,
//                length bytes included) is required; a mismatch aborts to ERR.
//    undefined - no CHECK state, no accumulator; last WRITE goes to DONE.
//
// Parameters:
//    BASE_ADDR  byte address of the first word written
//    DEPTH      instruction memory capacity in words (max accepted N)
//
// Ports:
//    clk         rising-edge clock
//    rst         synchronous active-high reset
//    start       begin a load (honoured in IDLE, DONE and ERR only)
//    byte_valid  source has a byte on byte_data
//    byte_data   stream byte
//    byte_ready  loader accepts a byte this cycle
//    imem_we     one-cycle write strobe
//    imem_addr   word-aligned byte address of the write
//    imem_wdata  assembled instruction word
//    cpu_hold    stalls PC/pipeline while loading (and after an abort)
//    done        level: last load completed
//    error       level: last load aborted
//    word_count  words written in the current or last load
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'd0,
   parameter int          DEPTH     = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error,
   output logic [15:0] word_count
);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
   } state_t;
`endif

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   state_t      state, state_next;
   logic [15:0] len;
   logic [1:0]  byte_idx;
   logic [31:0] shreg;
   logic        xfer;
   logic        restart;
   logic [15:0] n_in;
   logic [15:0] wc_inc;

   // next-cycle values of the registered status outputs
   logic        ready_next, we_next, hold_next, done_next, err_next;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign xfer    = byte_valid && byte_ready;
   assign restart = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
   // length as it will be latched on the LEN_LO transfer
   assign n_in    = {len[15:8], byte_data};
   assign wc_inc  = word_count + 16'd1;

   assign imem_addr  = BASE_ADDR + {14'd0, word_count, 2'b00};
   assign imem_wdata = shreg;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // ------------------------------------------------------ next state/outs
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (xfer) state_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (xfer) begin
               if (n_in == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                  state_next = S_CHECK;
`else
                  state_next = S_DONE;
`endif
               end else if ({1'b0, n_in} > DEPTH_W) begin
                  state_next = S_ERR;
               end else begin
                  state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer && byte_idx == 2'd3) state_next = S_WRITE;
         end
         S_WRITE: begin
            if (wc_inc == len) begin
`ifdef LOADER_CHECKSUM_EN
               state_next = S_CHECK;
`else
               state_next = S_DONE;
`endif
            end else begin
               state_next = S_DATA;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (xfer) state_next = (byte_data == csum) ? S_DONE : S_ERR;
         end
`endif
         default: state_next = S_IDLE;
      endcase

      // status outputs are registered off the state being entered
      ready_next = 1'b0;
      we_next    = 1'b0;
      hold_next  = 1'b1;
      done_next  = 1'b0;
      err_next   = 1'b0;
      case (state_next)
         S_IDLE:   hold_next  = 1'b0;
         S_LEN_HI: ready_next = 1'b1;
         S_LEN_LO: ready_next = 1'b1;
         S_DATA:   ready_next = 1'b1;
         S_WRITE:  we_next    = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         S_CHECK:  ready_next = 1'b1;
`endif
         S_DONE: begin
            hold_next = 1'b0;
            done_next = 1'b1;
         end
         S_ERR:    err_next   = 1'b1;  // memory contents invalid: keep CPU held
         default:  hold_next  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         cpu_hold   <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         byte_ready <= ready_next;
         imem_we    <= we_next;
         cpu_hold   <= hold_next;
         done       <= done_next;
         error      <= err_next;
      end
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         len        <= 16'd0;
         byte_idx   <= 2'd0;
         shreg      <= 32'd0;
         word_count <= 16'd0;
      end else begin
         if (restart) begin
            word_count <= 16'd0;
            byte_idx   <= 2'd0;
         end
         case (state)
            S_LEN_HI: if (xfer) len[15:8] <= byte_data;
            S_LEN_LO: if (xfer) len[7:0]  <= byte_data;
            S_DATA: begin
               if (xfer) begin
                  shreg    <= {shreg[23:0], byte_data};
                  byte_idx <= byte_idx + 2'd1;  // wraps to 0 after the 4th byte
               end
            end
            S_WRITE:  word_count <= wc_inc;
            default: ;
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // running XOR of every byte since start, length bytes included,
   // excluding the checksum byte itself
   always_ff @(posedge clk) begin
      if (rst) begin
         csum <= 8'd0;
      end else if (restart) begin
         csum <= 8'd0;
      end else if (xfer && state != S_CHECK) begin
         csum <= csum ^ byte_data;
      end
   end
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
   localparam logic [31:0] BASE  = 32'h40;
   localparam int          DEPTH = 64;
`ifdef LOADER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst, start, byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready, imem_we, cpu_hold, done, error;
   logic [31:0] imem_addr, imem_wdata;
   logic [15:0] word_count;

   imem_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
      .done(done), .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;
   int nwrites = 0, stall_cnt = 0;
   logic [31:0] last_addr = '0, last_data = '0;
   wr_t exp_q[$];
   wr_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // every write strobe must match the next expected write
   always @(negedge clk) begin
      if (!rst) begin
         if (imem_we) begin
            nwrites++;
            last_addr = imem_addr;
            last_data = imem_wdata;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write addr=%0h data=%0h", imem_addr, imem_wdata);
            end else begin
               mon_e = exp_q.pop_front();
               chk("write_addr", imem_addr, mon_e.addr);
               chk("write_data", imem_wdata, mon_e.data);
               chk("ready_during_write", byte_ready, 0);
            end
         end
         if (cpu_hold && !byte_ready) stall_cnt++;
         chk("done_error_exclusive", done & error, 0);
      end
   end

   // model: parse the stream per the format rules, queue expected writes
   task automatic model(input bq_t q, output bit ok, output int wc, output int lat);
      int n;
      logic [7:0] x;
      n = {q[0], q[1]};
      x = q[0] ^ q[1];
      if (n > DEPTH) begin
         ok = 0; wc = 0; lat = 2;
      end else begin
         for (int i = 0; i < n; i++) begin
            wr_t w;
            w.addr = BASE + 32'(4 * i);
            w.data = {q[2+4*i], q[3+4*i], q[4+4*i], q[5+4*i]};
            x = x ^ q[2+4*i] ^ q[3+4*i] ^ q[4+4*i] ^ q[5+4*i];
            exp_q.push_back(w);
         end
         ok  = 1;
         wc  = n;
         lat = 2 + 5 * n + CS;
         if (CS == 1) ok = (q.size() > 2 + 4 * n) && (q[2+4*n] == x);
      end
   endtask

   task automatic do_start(output int s);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      s = cyc;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      logic r;
      int budget = 0;
      if (gaps) begin
         for (int k = 0; k < 8 && $urandom_range(1, 0) == 0; k++) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      byte_valid = 1'b1;
      byte_data  = b;
      forever begin
         @(negedge clk); r = byte_ready;
         @(posedge clk); #1;
         if (r) break;
         budget++;
         if (budget > 100) begin
            checks++; errors++;
            $display("FAIL byte_accept_timeout byte=%0h", b);
            break;
         end
      end
   endtask

   task automatic wait_end(output int c);
      int budget = 0;
      while (!(done || error) && budget < 2000) begin
         @(posedge clk); #1;
         budget++;
      end
      c = cyc;
      if (budget >= 2000) begin
         checks++; errors++;
         $display("FAIL load_end_timeout done=%0b error=%0b", done, error);
      end
   endtask

   // full load: raw=0 appends the checksum byte when that feature is built in
   task automatic run_load(input bq_t q0, input bit gaps, input bit raw);
      bq_t q;
      bit ok;
      int wc, lat, s, c;
      logic [7:0] x;
      q = q0;
      if (CS == 1 && !raw && ({q[0], q[1]} <= DEPTH)) begin
         x = 8'h00;
         foreach (q[i]) x ^= q[i];
         q.push_back(x);
      end
      model(q, ok, wc, lat);
      do_start(s);
      stall_cnt = 0;
      foreach (q[i]) begin
         if (!ok && {q[0], q[1]} > DEPTH && i > 1) break;
         send_byte(q[i], gaps);
      end
      byte_valid = 1'b0;
      wait_end(c);
      if (!gaps) chk("latency", c - s, lat);
      chk("done", done, ok);
      chk("error", error, !ok);
      chk("cpu_hold", cpu_hold, !ok);
      chk("word_count", word_count, wc);
      chk("writes_outstanding", exp_q.size(), 0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_byte_ready", byte_ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, BASE);
      chk("rst_imem_wdata", imem_wdata, 0);
      chk("rst_cpu_hold", cpu_hold, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_word_count", word_count, 0);
   endtask

   bq_t q;
   int  w0, s0;

   initial begin
      rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals();
      rst = 1'b0;
      @(posedge clk); #1;

      // single word, gap-free
      w0 = nwrites;
      run_load('{8'h00, 8'h01, 8'h8C, 8'h01, 8'h00, 8'h04}, 0, 0);
      chk("t1_nwrites", nwrites - w0, 1);
      chk("t1_addr", last_addr, 32'h40);
      chk("t1_data", last_data, 32'h8C010004);

      // three words, one ready bubble per word
      run_load('{8'h00, 8'h03, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                 8'h33, 8'h33, 8'h33, 8'h33}, 0, 0);
      chk("t3_word_count", word_count, 16'd3);
      chk("t3_last_addr", last_addr, 32'h48);
      chk("t3_last_data", last_data, 32'h33333333);
      chk("t3_bubbles", stall_cnt, 3);

      // N > DEPTH aborts with no writes; start then clears error
      w0 = nwrites;
      run_load('{8'h00, 8'h41}, 0, 0);
      chk("ovf_error", error, 1);
      chk("ovf_hold", cpu_hold, 1);
      chk("ovf_nwrites", nwrites - w0, 0);
      do_start(s0);
      chk("restart_error_clr", error, 0);
      chk("restart_ready", byte_ready, 1);
      chk("restart_hold", cpu_hold, 1);
      // start in LEN_HI is ignored; this load continues from there
      run_load('{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67}, 0, 0);

      // same stream with random valid gaps
      run_load('{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67}, 1, 0);
      chk("gap_last_data", last_data, 32'h01234567);
      chk("gap_last_addr", last_addr, 32'h44);

      // empty load
      run_load('{8'h00, 8'h00}, 0, 0);
      chk("n0_word_count", word_count, 0);

      // reset after the 2nd byte of the second word
      exp_q.push_back('{addr: BASE, data: 32'hCAFEF00D});
      do_start(s0);
      q = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hAA, 8'hBB};
      foreach (q[i]) send_byte(q[i], 0);
      byte_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_vals();
      rst = 1'b0;
      chk("rst_writes_outstanding", exp_q.size(), 0);
      @(posedge clk); #1;
      run_load('{8'h00, 8'h01, 8'h8C, 8'h01, 8'h00, 8'h04}, 0, 0);
      chk("post_rst_addr", last_addr, BASE);

      // N == DEPTH accepted
      q = '{8'h00, 8'h40};
      for (int i = 0; i < DEPTH; i++) begin
         q.push_back(8'(i)); q.push_back(8'hA5); q.push_back(8'(i * 3)); q.push_back(8'h5A);
      end
      run_load(q, 0, 0);
      chk("full_last_addr", last_addr, 32'h13C);
      chk("full_last_data", last_data, 32'h3FA5BD5A);

`ifdef LOADER_CHECKSUM_EN
      run_load('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09}, 0, 1);
      chk("cs_good_done", done, 1);
      run_load('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08}, 0, 1);
      chk("cs_bad_error", error, 1);
      chk("cs_bad_hold", cpu_hold, 1);
`endif

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
